// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM state type and default 320x240 serial-RGB timing for the LCD byte timing generator
package lcd_pkg;
  typedef enum logic {SEEK, RUN} state_t;
  localparam int LCD_H_SYNC = 1;
  localparam int LCD_H_BACK = 152;
  localparam int LCD_H_ACT = 960;
  localparam int LCD_H_FRONT = 20;
  localparam int LCD_V_SYNC = 1;
  localparam int LCD_V_BACK = 13;
  localparam int LCD_V_ACT = 240;
  localparam int LCD_V_FRONT = 4;
  localparam logic [7:0] LCD_FILL = 8'h00;
endpackage

// File: rtl/lcd_byte_timing_gen_if.sv
// lcd_byte_timing_gen_if: 8-bit Avalon-ST byte stream feeding the LCD timing generator
interface lcd_byte_timing_gen_if;
  logic in_ready;
  logic in_valid;
  logic [7:0] in_data;
  logic in_startofpacket;
  logic in_endofpacket;
  logic in_empty;
  modport master (input in_ready, output in_valid, in_data, in_startofpacket, in_endofpacket, in_empty);
  modport slave (output in_ready, input in_valid, in_data, in_startofpacket, in_endofpacket, in_empty);
endinterface

// File: rtl/lcd_sync_counter.sv
// lcd_sync_counter: one timing axis (sync/back/active/front), advancing on request and flagging its wrap
module lcd_sync_counter #(
  parameter int SYNC = 1,
  parameter int BACK = 1,
  parameter int ACT = 1,
  parameter int FRONT = 1,
  parameter int W = $clog2(SYNC + BACK + ACT + FRONT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] cnt,
  output logic         sync_n,
  output logic         active,
  output logic         wrap
);
  localparam int TOT = SYNC + BACK + ACT + FRONT;
  localparam int A0 = SYNC + BACK;
  localparam int A1 = A0 + ACT;
  assign wrap = advance && cnt == W'(TOT - 1);
  assign sync_n = cnt >= W'(SYNC);
  assign active = cnt >= W'(A0) && cnt < W'(A1);
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (advance) cnt <= wrap ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/lcd_byte_timing_gen.sv
// lcd_byte_timing_gen: locks an Avalon-ST byte stream to serial-RGB LCD timing, filling gaps with FILL.
// Define LCD_UNDERFLOW_COUNT_EN to add the saturating underflow_cnt output.
module lcd_byte_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_SYNC = LCD_H_SYNC,
  parameter int H_BACK = LCD_H_BACK,
  parameter int H_ACT = LCD_H_ACT,
  parameter int H_FRONT = LCD_H_FRONT,
  parameter int V_SYNC = LCD_V_SYNC,
  parameter int V_BACK = LCD_V_BACK,
  parameter int V_ACT = LCD_V_ACT,
  parameter int V_FRONT = LCD_V_FRONT,
  parameter logic [7:0] FILL = LCD_FILL
) (
  input  logic       clk,
  input  logic       reset,
  lcd_byte_timing_gen_if.slave st,
  output logic       lcd_hsync_n,
  output logic       lcd_vsync_n,
  output logic       lcd_den,
  output logic [7:0] lcd_data,
`ifdef LCD_UNDERFLOW_COUNT_EN
  output logic [15:0] underflow_cnt,
`endif
  output logic       underflow
);
  localparam int HW = $clog2(H_SYNC + H_BACK + H_ACT + H_FRONT);
  localparam int VW = $clog2(V_SYNC + V_BACK + V_ACT + V_FRONT);
  localparam int HA0 = H_SYNC + H_BACK;
  localparam int HA1 = HA0 + H_ACT - 1;
  localparam int VA0 = V_SYNC + V_BACK;
  localparam int VA1 = VA0 + V_ACT - 1;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic h_sync_n, v_sync_n, h_act, v_act, h_wrap, v_wrap;
  logic act, first, last, sop_head, lock, take, abort, fill_run, uf_d;
  logic [7:0] data_d;
  logic unused_sig;
  state_t state, state_d;
  lcd_sync_counter #(.SYNC(H_SYNC), .BACK(H_BACK), .ACT(H_ACT), .FRONT(H_FRONT)) u_h (
    .clk(clk), .reset(reset), .advance(1'b1), .cnt(hcnt), .sync_n(h_sync_n), .active(h_act), .wrap(h_wrap)
  );
  lcd_sync_counter #(.SYNC(V_SYNC), .BACK(V_BACK), .ACT(V_ACT), .FRONT(V_FRONT)) u_v (
    .clk(clk), .reset(reset), .advance(h_wrap), .cnt(vcnt), .sync_n(v_sync_n), .active(v_act), .wrap(v_wrap)
  );
  assign unused_sig = ^{st.in_endofpacket, st.in_empty, v_wrap};
  // A pending SOP is held off until the frame's first active byte; anything else ahead of it is dropped.
  assign st.in_ready = !reset && (state == SEEK ? !sop_head || first : act && !sop_head);
  always_comb begin
    act = h_act && v_act;
    first = act && hcnt == HW'(HA0) && vcnt == VW'(VA0);
    last = act && hcnt == HW'(HA1) && vcnt == VW'(VA1);
    sop_head = st.in_valid && st.in_startofpacket;
    lock = state == SEEK && first && sop_head;
    take = state == RUN && act && st.in_valid && !st.in_startofpacket;
    abort = state == RUN && act && sop_head;
    fill_run = state == RUN && act && !take;
    state_d = lock && !last ? RUN : state == RUN && (last || abort) ? SEEK : state;
    data_d = lock || take ? st.in_data : FILL;
    uf_d = lock ? 1'b0 : fill_run || underflow;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= SEEK;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lcd_hsync_n <= 1'b1;
      lcd_vsync_n <= 1'b1;
      lcd_den <= 1'b0;
      lcd_data <= 8'h00;
      underflow <= 1'b0;
    end else begin
      lcd_hsync_n <= h_sync_n;
      lcd_vsync_n <= v_sync_n;
      lcd_den <= act;
      lcd_data <= data_d;
      underflow <= uf_d;
    end
  end
`ifdef LCD_UNDERFLOW_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || lock) underflow_cnt <= 16'h0000;
    else if (fill_run && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'h0001;
  end
`endif
endmodule

// File: tb/tb_lcd_byte_timing_gen.sv
// tb_lcd_byte_timing_gen: directed scenarios on a 10x5 timing grid (6 active bytes x 2 active lines)
module tb_lcd_byte_timing_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  lcd_byte_timing_gen_if st();
  logic hs, vs, den, uf;
  logic [7:0] data;
`ifdef LCD_UNDERFLOW_COUNT_EN
  logic [15:0] ucnt;
`endif
  lcd_byte_timing_gen #(
    .H_SYNC(1), .H_BACK(2), .H_ACT(6), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACT(2), .V_FRONT(1), .FILL(8'h00)
  ) u_dut (
    .clk(clk), .reset(reset), .st(st),
    .lcd_hsync_n(hs), .lcd_vsync_n(vs), .lcd_den(den), .lcd_data(data),
`ifdef LCD_UNDERFLOW_COUNT_EN
    .underflow_cnt(ucnt),
`endif
    .underflow(uf)
  );
  typedef struct {logic [7:0] d; logic sop; logic gap;} ent_t;
  ent_t src[$];
  logic [7:0] cap[$];
  logic [7:0] exp[$];
  bit cap_en = 0;
  int total = 0;
  int bad = 0;
  always @(negedge clk) if (cap_en && den) cap.push_back(data);
  task automatic push_bytes(input logic [7:0] base, input int n, input logic sop, input logic [15:0] gaps);
    for (int i = 0; i < n; i++) src.push_back('{d: base + 8'(i), sop: sop && i == 0, gap: gaps[i]});
  endtask
  task automatic drive(input int n);
    logic fire;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (src.size() > 0) begin
        st.in_valid = 1'b1; st.in_data = src[0].d; st.in_startofpacket = src[0].sop;
      end else begin
        st.in_valid = 1'b0; st.in_data = 8'h00; st.in_startofpacket = 1'b0;
      end
      #2;
      if (src.size() > 0 && src[0].gap && st.in_ready) begin
        st.in_valid = 1'b0; src[0].gap = 1'b0; #1;
      end
      fire = st.in_valid && st.in_ready;
      @(posedge clk);
      if (fire) void'(src.pop_front());
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cap_en = 0;
    st.in_valid = 1'b0; st.in_data = 8'h00; st.in_startofpacket = 1'b0;
    st.in_endofpacket = 1'b0; st.in_empty = 1'b0;
    src.delete(); cap.delete(); exp.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0; cap_en = 1;
  endtask
  task automatic check_cap(input string name);
    total++;
    if (cap.size() != exp.size()) begin
      bad++; $display("FAIL %s count got=%0d want=%0d", name, cap.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp[i]) begin
        bad++; $display("FAIL %s byte%0d got=%h want=%h", name, i, cap[i], exp[i]);
      end
    end
  endtask
  task automatic test_reset();
    int hl, vl, dn, nz;
    do_reset();
    cap_en = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    total++;
    if ({hs, vs, den, data, uf, st.in_ready} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_outs got=%b want=%b", {hs, vs, den, data, uf, st.in_ready}, 13'b1100000000000);
    end
    reset = 1'b0;
    hl = 0; vl = 0; dn = 0; nz = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hl += int'(!hs); vl += int'(!vs); dn += int'(den); nz += int'(den && data != 8'h00);
    end
    total++; if (hl !== 5) begin bad++; $display("FAIL hsync_low got=%0d want=5", hl); end
    total++; if (vl !== 10) begin bad++; $display("FAIL vsync_low got=%0d want=10", vl); end
    total++; if (dn !== 12) begin bad++; $display("FAIL den_count got=%0d want=12", dn); end
    total++; if (nz !== 0) begin bad++; $display("FAIL idle_fill got=%0d want=0", nz); end
  endtask
  task automatic test_full_frame();
    do_reset();
    push_bytes(8'h01, 12, 1'b1, 16'h0000);
    drive(60);
    for (int i = 1; i <= 12; i++) exp.push_back(8'(i));
    check_cap("full_frame");
    total++; if (uf !== 1'b0) begin bad++; $display("FAIL full_frame_uf got=%b want=0", uf); end
  endtask
  task automatic test_gap();
    do_reset();
    push_bytes(8'h01, 12, 1'b1, 16'h0004);
    drive(60);
    exp = '{8'h01, 8'h02, 8'h00, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    check_cap("gap");
    total++; if (uf !== 1'b1) begin bad++; $display("FAIL gap_uf got=%b want=1", uf); end
  endtask
  task automatic test_garbage();
    do_reset();
    push_bytes(8'hA0, 4, 1'b0, 16'h0000);
    push_bytes(8'h01, 12, 1'b1, 16'h0000);
    drive(6);
    total++; if (src.size() !== 12) begin bad++; $display("FAIL garbage_drop got=%0d want=12", src.size()); end
    drive(60);
    for (int i = 1; i <= 12; i++) exp.push_back(8'(i));
    check_cap("garbage");
    total++; if (uf !== 1'b0) begin bad++; $display("FAIL garbage_uf got=%b want=0", uf); end
  endtask
  task automatic test_sop_inject();
    do_reset();
    push_bytes(8'h01, 4, 1'b1, 16'h0000);
    push_bytes(8'h11, 12, 1'b1, 16'h0000);
    drive(45);
    total++; if (uf !== 1'b1) begin bad++; $display("FAIL inject_uf got=%b want=1", uf); end
    drive(60);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 8; i++) exp.push_back(8'h00);
    for (int i = 0; i < 12; i++) exp.push_back(8'h11 + 8'(i));
    check_cap("inject");
    total++; if (uf !== 1'b0) begin bad++; $display("FAIL relock_uf got=%b want=0", uf); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    push_bytes(8'h01, 12, 1'b1, 16'h0004);
    drive(28);
    @(negedge clk);
    total++;
    if ({den, data, uf} !== {1'b1, 8'h05, 1'b1}) begin
      bad++; $display("FAIL pre_reset got=%b want=%b", {den, data, uf}, 10'b1000001011);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({hs, vs, den, data, uf, st.in_ready} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mid_reset_outs got=%b want=%b", {hs, vs, den, data, uf, st.in_ready}, 13'b1100000000000);
    end
    total++;
    if ({u_dut.hcnt, u_dut.vcnt} !== 7'd0) begin
      bad++; $display("FAIL mid_reset_cnt got=%0d/%0d want=0/0", u_dut.hcnt, u_dut.vcnt);
    end
    reset = 1'b0;
  endtask
`ifdef LCD_UNDERFLOW_COUNT_EN
  task automatic test_underflow_cnt();
    do_reset();
    push_bytes(8'h01, 12, 1'b1, 16'h0124);
    drive(45);
    total++; if (ucnt !== 16'd3) begin bad++; $display("FAIL ucnt got=%0d want=3", ucnt); end
    push_bytes(8'h21, 12, 1'b1, 16'h0000);
    drive(60);
    total++; if (ucnt !== 16'd0) begin bad++; $display("FAIL ucnt_clear got=%0d want=0", ucnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_full_frame();
    test_gap();
    test_garbage();
    test_sop_inject();
    test_reset_mid();
`ifdef LCD_UNDERFLOW_COUNT_EN
    test_underflow_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
